// File: rtl/nibble_serial_cla_adder.sv
`default_nettype none
// ============================================================================
// Module      : cla4_slice / nibble_serial_cla_adder
// Description : WIDTH-bit adder that reuses one 4-bit augmented carry-lookahead
//               slice once per clock, LSB nibble first. The slice's block
//               propagate/generate pair forms the registered inter-nibble
//               carry.
// Revision    : 1.0 - initial release
// ============================================================================

// 4-bit carry-lookahead slice, augmented with block propagate/generate outputs.
module cla4_slice (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_bp,
    output logic       o_bg
);

    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [3:0] w_c;

    // Per-bit propagate and generate terms.
    for (genvar gi = 0; gi < 4; gi++) begin : g_bit
        assign w_p[gi] = i_a[gi] ^ i_b[gi];
        assign w_g[gi] = i_a[gi] & i_b[gi];
    end

    // Flattened lookahead: every internal carry depends only on p/g and cin.
    always_comb begin
        w_c[0] = i_cin;
        w_c[1] = w_g[0] | (w_p[0] & i_cin);
        w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
        w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & i_cin);
    end

    assign o_sum = w_p ^ w_c;
    assign o_bp  = &w_p;
    assign o_bg  = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

endmodule

// Multi-cycle adder: one nibble per RUN cycle, result published on DONE.
// WIDTH must be a multiple of 4 and at least 8.
module nibble_serial_cla_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [1:0]      c_idle = 2'd0;
    localparam logic [1:0]      c_run  = 2'd1;
    localparam logic [1:0]      c_done = 2'd2;
    localparam logic [IDXW-1:0] c_last = IDXW'(NIB - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_busy;
    logic             r_done;

    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [3:0]       w_s_nib;
    logic             w_bp;
    logic             w_bg;
    logic             w_carry_next;
    logic [WIDTH-1:0] w_acc_next;

    assign w_a_nib = r_a[4*r_idx +: 4];
    assign w_b_nib = r_b[4*r_idx +: 4];

    cla4_slice u_slice (
        .i_a   (w_a_nib),
        .i_b   (w_b_nib),
        .i_cin (r_carry),
        .o_sum (w_s_nib),
        .o_bp  (w_bp),
        .o_bg  (w_bg)
    );

    assign w_carry_next = w_bg | (w_bp & r_carry);

    // Accumulator with the current nibble merged in, so DONE can publish the
    // full result on the same edge that computes the last nibble.
    always_comb begin
        w_acc_next = r_acc;
        w_acc_next[4*r_idx +: 4] = w_s_nib;
    end

    // Control FSM plus all datapath registers; outputs are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= c_run;
                    end
                end
                c_run: begin
                    r_acc   <= w_acc_next;
                    r_carry <= w_carry_next;
                    r_idx   <= r_idx + IDXW'(1);
                    if (r_idx == c_last) begin
                        r_sum   <= w_acc_next;
                        r_cout  <= w_carry_next;
                        r_ovf   <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                                   (w_acc_next[WIDTH-1] != r_a[WIDTH-1]);
                        r_done  <= 1'b1;
                        r_state <= c_done;
                    end
                end
                c_done: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= c_idle;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_cla_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_serial_cla_adder
// Description : Self-checking bench for nibble_serial_cla_adder (WIDTH=16).
//               Expected results come from plain integer addition.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_cla_adder;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int total;
    int bad;

    nibble_serial_cla_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one add and check latency, handshake, hold behaviour and result.
    // When disturb is set, a second start and operand changes happen mid-run.
    task automatic run_add(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                           input logic tcin, input bit disturb);
        logic [16:0] ref_full;
        logic [15:0] ref_sum;
        logic        ref_ovf;
        logic [15:0] old_sum;
        logic        old_cout;
        int          lat;
        int          busy_cnt;
        bit          seen;
        ref_full = {1'b0, ta} + {1'b0, tb_} + {16'd0, tcin};
        ref_sum  = ref_full[15:0];
        ref_ovf  = (ta[15] == tb_[15]) && (ref_sum[15] != ta[15]);
        old_sum  = sum;
        old_cout = cout;
        @(negedge clk);
        a = ta; b = tb_; cin = tcin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0; busy_cnt = 0; seen = 0;
        while (!seen && lat < 20) begin
            if (busy) busy_cnt++;
            if (done) begin
                seen = 1;
            end else begin
                if (lat == 0 || lat == 2) begin
                    total++;
                    assert (sum === old_sum && cout === old_cout) else begin
                        bad++;
                        $error("FAIL %s_hold observed=0x%0h expected=0x%0h", tag, sum, old_sum);
                    end
                end
                if (disturb && lat == 1) begin
                    start = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = ~tcin;
                end else begin
                    start = 1'b0;
                    a = 16'($urandom); b = 16'($urandom);
                end
                @(negedge clk);
                lat++;
            end
        end
        start = 1'b0;
        chk({tag, "_latency"}, 32'(lat), 32'd4);
        chk({tag, "_sum"}, 32'(sum), 32'(ref_sum));
        chk({tag, "_cout"}, 32'(cout), 32'(ref_full[16]));
        chk({tag, "_ovf"}, 32'(ovf), 32'(ref_ovf));
        chk({tag, "_busycnt"}, 32'(busy_cnt), 32'd5);
        @(negedge clk);
        chk({tag, "_done_1cyc"}, 32'(done), 32'd0);
        chk({tag, "_busy_off"}, 32'(busy), 32'd0);
        if (disturb) begin
            // A queued second start would produce another done pulse.
            for (int i = 0; i < 7; i++) begin
                @(negedge clk);
                chk({tag, "_no_extra_done"}, 32'(done), 32'd0);
            end
        end
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;

        run_add("zero", 16'h0000, 16'h0000, 1'b0, 0);
        run_add("small", 16'h0005, 16'h0001, 1'b0, 0);
        run_add("prop", 16'h0FFF, 16'h0000, 1'b1, 0);
        run_add("wrap", 16'hFFFF, 16'h0001, 1'b0, 0);
        run_add("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 0);
        run_add("ovf_neg", 16'h8000, 16'h8000, 1'b0, 0);
        run_add("disturb", 16'h1234, 16'h1111, 1'b0, 1);

        // Reset on the second RUN cycle aborts the add.
        @(negedge clk);
        a = 16'h00FF; b = 16'h0001; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        chk("abort_ovf", 32'(ovf), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'd0);
        end
        run_add("after_abort", 16'h0003, 16'h0004, 1'b0, 0);

        for (int i = 0; i < 20; i++) begin
            run_add("rand", 16'($urandom), 16'($urandom), 1'($urandom), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
